// File: rtl/axi_scratch_slv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// axi_scratch_slv : AXI4 INCR-burst scratchpad slave, one array entry per beat.
//   Optional size checking is enabled with AXI_SCRATCH_SIZE_CHK_EN.
// Revision: 1.0
// ============================================================================
module axi_scratch_slv #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 6,
  parameter int DEPTH  = 16,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [63:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [63:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ERR_W-1:0]    err_cnt
);
  localparam int SW = DATA_W / 8;
  localparam int LB = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  localparam logic [2:0] SIZE_FULL = 3'(LB);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [IW-1:0]     aw_idx_q, aw_idx_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [8:0]        w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d, w_serr_q, w_serr_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic              mem_we;
  logic [IW-1:0]     w_addr;

  r_state_e          r_state_q, r_state_d;
  logic [IW-1:0]     ar_idx_q, ar_idx_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              r_serr_q, r_serr_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IW-1:0]     r_raddr;

  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ERR_W:0]    err_sum;
  logic              aw_size_bad, ar_size_bad;
  logic              w_unused;

`ifdef AXI_SCRATCH_SIZE_CHK_EN
  assign aw_size_bad = (s_axi_awsize != SIZE_FULL);
  assign ar_size_bad = (s_axi_arsize != SIZE_FULL);
  assign w_unused = ^{s_axi_awaddr[63:LB+IW], s_axi_awaddr[LB-1:0],
                      s_axi_araddr[63:LB+IW], s_axi_araddr[LB-1:0],
                      s_axi_awburst, s_axi_arburst};
`else
  assign aw_size_bad = 1'b0;
  assign ar_size_bad = 1'b0;
  assign w_unused = ^{s_axi_awaddr[63:LB+IW], s_axi_awaddr[LB-1:0],
                      s_axi_araddr[63:LB+IW], s_axi_araddr[LB-1:0],
                      s_axi_awburst, s_axi_arburst, s_axi_awsize,
                      s_axi_arsize, SIZE_FULL};
`endif

  always_comb begin
    w_state_d = w_state_q;
    aw_id_d   = aw_id_q;
    aw_idx_d  = aw_idx_q;
    aw_len_d  = aw_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_serr_d  = w_serr_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we    = 1'b0;
    w_addr    = aw_idx_q + IW'(w_cnt_q);
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_id_d   = s_axi_awid;
          aw_idx_d  = s_axi_awaddr[LB +: IW];
          aw_len_d  = s_axi_awlen;
          w_cnt_d   = 9'd0;
          w_err_d   = 1'b0;
          w_serr_d  = aw_size_bad;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          // the count stops at len+1 so surplus beats are recognised and dropped
          if (w_cnt_q <= {1'b0, aw_len_q}) begin
            mem_we  = !w_serr_q;
            w_cnt_d = w_cnt_q + 9'd1;
          end else begin
            w_err_d = 1'b1;
          end
          if (s_axi_wlast) begin
            if (w_cnt_q < {1'b0, aw_len_q}) w_err_d = 1'b1;
            w_state_d = W_RESP;
            bid_d     = aw_id_q;
            bresp_d   = (w_err_d || w_serr_q) ? 2'b10 : 2'b00;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          w_state_d = W_IDLE;
          bresp_d   = 2'b00;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_idx_d  = ar_idx_q;
    ar_len_d  = ar_len_q;
    r_cnt_d   = r_cnt_q;
    r_serr_d  = r_serr_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    r_raddr   = ar_idx_q + IW'(r_cnt_q + 8'd1);
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_state_d = R_DATA;
          ar_idx_d  = s_axi_araddr[LB +: IW];
          ar_len_d  = s_axi_arlen;
          r_cnt_d   = 8'd0;
          r_serr_d  = ar_size_bad;
          r_raddr   = s_axi_araddr[LB +: IW];
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          rlast_d   = (s_axi_arlen == 8'd0);
          rresp_d   = ar_size_bad ? 2'b10 : 2'b00;
          rdata_d   = ar_size_bad ? '0 : mem[r_raddr];
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = (r_cnt_d == ar_len_q);
            rdata_d = r_serr_q ? '0 : mem[r_raddr];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_comb begin
    err_sum = {1'b0, err_cnt_q}
            + (ERR_W+1)'(bvalid_q && s_axi_bready && bresp_q[1])
            + (ERR_W+1)'(rvalid_q && s_axi_rready && rresp_q[1]);
    err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // read-first: rdata_q samples mem before this edge's write lands
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi_wstrb[b]) mem[w_addr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
      aw_idx_q  <= '0;
      aw_len_q  <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      w_serr_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      aw_idx_q  <= aw_idx_d;
      aw_len_q  <= aw_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_serr_q  <= w_serr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      ar_idx_q  <= '0;
      ar_len_q  <= '0;
      r_cnt_q   <= '0;
      r_serr_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_idx_q  <= ar_idx_d;
      ar_len_q  <= ar_len_d;
      r_cnt_q   <= r_cnt_d;
      r_serr_q  <= r_serr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign err_cnt       = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_scratch_slv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_axi_scratch_slv : randomized scoreboard bench for axi_scratch_slv.
// Revision: 1.0
// ============================================================================
module tb_axi_scratch_slv;
  localparam int DW = 512, IDW = 6, D = 16, EW = 16, SW = 64, LB = 6;
  localparam logic [2:0] SZ = 3'(LB);

  logic clk, rst_n;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [63:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [EW-1:0] err_cnt;

  axi_scratch_slv #(.DATA_W(DW), .ID_W(IDW), .DEPTH(D), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, exp_err = 0, rr_mode = 0;
  logic [DW-1:0] ref_mem [D];
  logic [DW-1:0] old_mem [D];
  logic [DW-1:0] wb_data [32];
  logic [SW-1:0] wb_strb [32];

  typedef struct {logic [DW-1:0] d0; logic [DW-1:0] d1; logic [IDW-1:0] id; logic [1:0] resp; logic last;} rexp_t;
  typedef struct {logic [IDW-1:0] id; logic [1:0] resp;} bexp_t;
  rexp_t r_q[$];
  bexp_t b_q[$];

  task automatic check_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: entry (idx+k) mod D takes strobed bytes of beat k for k<=len.
  function automatic void gen_write(input logic [IDW-1:0] id, input int idx, input int len,
                                    input int nbeats, input bit size_bad, input int smode);
    bexp_t be;
    for (int k = 0; k < nbeats; k++) begin
      wb_data[k] = rand_word();
      wb_strb[k] = (smode == 0) ? {SW{1'b1}} : (smode == 1) ? {$urandom, $urandom} : 64'h1;
      if (smode == 2) wb_data[k][7:0] = 8'hAA;
      if (!size_bad && k <= len)
        for (int b = 0; b < SW; b++)
          if (wb_strb[k][b]) ref_mem[(idx + k) % D][b*8 +: 8] = wb_data[k][b*8 +: 8];
    end
    be.id = id;
    be.resp = (size_bad || nbeats != len + 1) ? 2'b10 : 2'b00;
    b_q.push_back(be);
  endfunction

  function automatic void push_read(input logic [IDW-1:0] id, input int idx, input int len,
                                    input bit size_bad, input bit use_alt);
    rexp_t e;
    for (int k = 0; k <= len; k++) begin
      e.d0 = size_bad ? '0 : ref_mem[(idx + k) % D];
      e.d1 = size_bad ? '0 : (use_alt ? old_mem[(idx + k) % D] : e.d0);
      e.id = id;
      e.resp = size_bad ? 2'b10 : 2'b00;
      e.last = (k == len);
      r_q.push_back(e);
    end
  endfunction

  task automatic drive_write(input logic [IDW-1:0] id, input int idx, input int len, input int nbeats,
                             input logic [2:0] size, input int bdelay, input bit gaps);
    int t;
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awlen = 8'(len); awsize = size; awburst = 2'b01;
    awaddr = (64'($urandom) << (LB + 4)) | (64'(idx) << LB);
    for (t = 0; t < 100; t++) begin @(negedge clk); if (awready) break; end
    if (t == 100) begin check_eq("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge clk); #1; end
      wvalid = 1'b1; wdata = wb_data[k]; wstrb = wb_strb[k]; wlast = (k == nbeats - 1);
      for (t = 0; t < 100; t++) begin @(negedge clk); if (wready) break; end
      if (t == 100) begin check_eq("w_timeout", 0, 1); wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (bdelay > 0) begin
      for (int c = 0; c < bdelay; c++) begin
        @(negedge clk);
        check_eq("b_hold_bvalid", DW'(bvalid), 1);
        check_eq("b_hold_awready", DW'(awready), 0);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    for (t = 0; t < 100; t++) begin @(negedge clk); if (bvalid) break; end
    if (t == 100) check_eq("b_timeout", 0, 1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic drive_read(input logic [IDW-1:0] id, input int idx, input int len, input logic [2:0] size);
    int t;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; arlen = 8'(len); arsize = size; arburst = 2'b01;
    araddr = (64'($urandom) << (LB + 4)) | (64'(idx) << LB);
    for (t = 0; t < 100; t++) begin @(negedge clk); if (arready) break; end
    if (t == 100) begin check_eq("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check_eq("r_latency", DW'(rvalid), 1);
    for (t = 0; t < 400; t++) begin if (r_q.size() == 0) break; @(negedge clk); end
    if (t == 400) begin check_eq("r_timeout", DW'(r_q.size()), 0); r_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_awready", DW'(awready), 0);
    check_eq("rst_wready", DW'(wready), 0);
    check_eq("rst_bvalid", DW'(bvalid), 0);
    check_eq("rst_bresp", DW'(bresp), 0);
    check_eq("rst_bid", DW'(bid), 0);
    check_eq("rst_arready", DW'(arready), 0);
    check_eq("rst_rvalid", DW'(rvalid), 0);
    check_eq("rst_rlast", DW'(rlast), 0);
    check_eq("rst_rresp", DW'(rresp), 0);
    check_eq("rst_rid", DW'(rid), 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_err_cnt", DW'(err_cnt), 0);
  endtask

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = !rready;
        2: rready = 1'($urandom_range(0, 1));
        default: rready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks R hold-while-stalled.
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_rdata;
  logic [IDW-1:0] prev_rid;
  logic prev_rlast;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("r_stall_valid", DW'(rvalid), 1);
        check_eq("r_stall_data", rdata, prev_rdata);
        check_eq("r_stall_ctl", DW'({rid, rlast}), DW'({prev_rid, prev_rlast}));
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          check_eq("r_unexpected", DW'(rvalid), 0);
        end else begin
          rexp_t e;
          e = r_q.pop_front();
          checks++;
          if (rdata !== e.d0 && rdata !== e.d1) begin
            errors++;
            $display("FAIL r_data: got %0h expected %0h", rdata, e.d0);
          end
          check_eq("r_id", DW'(rid), DW'(e.id));
          check_eq("r_resp", DW'(rresp), DW'(e.resp));
          check_eq("r_last", DW'(rlast), DW'(e.last));
          if (e.resp == 2'b10) exp_err++;
        end
      end
      stall_prev = rvalid && !rready;
      prev_rdata = rdata; prev_rid = rid; prev_rlast = rlast;
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          check_eq("b_unexpected", DW'(bvalid), 0);
        end else begin
          bexp_t be;
          be = b_q.pop_front();
          check_eq("b_id", DW'(bid), DW'(be.id));
          check_eq("b_resp", DW'(bresp), DW'(be.resp));
          if (be.resp == 2'b10) exp_err++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int idx, len, nb, sm, bd;
  logic [IDW-1:0] id;
  initial begin
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = SZ; awburst = 1; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = SZ; arburst = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_awready", DW'(awready), 1);
    check_eq("idle_arready", DW'(arready), 1);

    gen_write(0, 0, 15, 16, 0, 0); drive_write(0, 0, 15, 16, SZ, 0, 0);
    // basic burst at addr 0x40
    gen_write(5, 1, 3, 4, 0, 0); drive_write(5, 1, 3, 4, SZ, 0, 0);
    push_read(5, 1, 3, 0, 0); drive_read(5, 1, 3, SZ);
    // single byte strobe, then wrap-around burst
    gen_write(9, 15, 0, 1, 0, 2); drive_write(9, 15, 0, 1, SZ, 0, 0);
    push_read(9, 15, 0, 0, 0); drive_read(9, 15, 0, SZ);
    gen_write(10, 14, 3, 4, 0, 1); drive_write(10, 14, 3, 4, SZ, 0, 1);
    push_read(10, 14, 3, 0, 0); drive_read(10, 14, 3, SZ);
    // early wlast, then surplus beats
    gen_write(3, 4, 1, 1, 0, 0); drive_write(3, 4, 1, 1, SZ, 0, 0);
    check_eq("err_cnt_early_last", DW'(err_cnt), DW'(exp_err));
    gen_write(3, 6, 0, 3, 0, 0); drive_write(3, 6, 0, 3, SZ, 0, 0);
    check_eq("err_cnt_surplus", DW'(err_cnt), DW'(exp_err));
    push_read(3, 4, 3, 0, 0); drive_read(3, 4, 3, SZ);
    // stalled reads, then read concurrent with a write to the same entries
    rr_mode = 1;
    push_read(7, 0, 7, 0, 0); drive_read(7, 0, 7, SZ);
    old_mem = ref_mem;
    gen_write(8, 0, 7, 8, 0, 1);
    push_read(8, 0, 7, 0, 1);
    fork
      drive_write(8, 0, 7, 8, SZ, 0, 1);
      drive_read(8, 0, 7, SZ);
    join
    rr_mode = 0;
    push_read(8, 0, 7, 0, 0); drive_read(8, 0, 7, SZ);
    // B back-pressure
    gen_write(12, 3, 2, 3, 0, 0); drive_write(12, 3, 2, 3, SZ, 10, 0);

    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, D - 1);
      len = $urandom_range(0, 7);
      id = IDW'($urandom);
      rr_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 2) : len + 1;
        sm = $urandom_range(0, 1);
        bd = $urandom_range(0, 3);
        gen_write(id, idx, len, nb, 0, sm); drive_write(id, idx, len, nb, SZ, bd, 1);
      end else begin
        push_read(id, idx, len, 0, 0); drive_read(id, idx, len, SZ);
      end
      check_eq("err_cnt_rand", DW'(err_cnt), DW'(exp_err));
    end
    rr_mode = 0;

`ifdef AXI_SCRATCH_SIZE_CHK_EN
    gen_write(4, 2, 1, 2, 1, 0); drive_write(4, 2, 1, 2, 3'b011, 0, 0);
    check_eq("err_cnt_awsize", DW'(err_cnt), DW'(exp_err));
    push_read(4, 2, 1, 1, 0); drive_read(4, 2, 1, 3'b011);
    check_eq("err_cnt_arsize", DW'(err_cnt), DW'(exp_err));
    push_read(4, 2, 1, 0, 0); drive_read(4, 2, 1, SZ);
`endif

    // reset while both a write and a read burst are in flight
    rr_mode = 3;
    @(posedge clk); #1;
    awvalid = 1; awid = 1; awaddr = 64'(3) << LB; awlen = 3; awsize = SZ;
    arvalid = 1; arid = 2; araddr = 64'(5) << LB; arlen = 3; arsize = SZ;
    @(negedge clk);
    check_eq("mid_rst_ready", DW'({awready, arready}), 2'b11);
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0;
    wvalid = 1; wdata = ref_mem[3]; wstrb = '1; wlast = 0;
    @(posedge clk); #1;
    wdata = ref_mem[4];
    @(negedge clk);
    check_eq("mid_rst_rvalid", DW'(rvalid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    wvalid = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rr_mode = 0;
    repeat (10) begin
      @(negedge clk);
      check_eq("post_rst_quiet", DW'({bvalid, rvalid}), 0);
    end

    gen_write(21, 9, 2, 3, 0, 1); drive_write(21, 9, 2, 3, SZ, 0, 0);
    push_read(22, 2, 11, 0, 0); drive_read(22, 2, 11, SZ);
    repeat (3) @(posedge clk);
    check_eq("r_q_drained", DW'(r_q.size()), 0);
    check_eq("b_q_drained", DW'(b_q.size()), 0);
    check_eq("err_cnt_final", DW'(err_cnt), DW'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
